// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Takes one operation per start handshake and computes MUL, MULH, MULHSU, MULHU, DIV, DIVU,
// REM and REMU. Signed operands are reduced to magnitudes when the operation is accepted.
// An unsigned shift-add / restoring-divide core then resolves one bit per cycle in a
// 2*DATA_WIDTH accumulator. The result is sign-corrected on the edge that enters DONE.
//
// Optional feature: define MULDIV_FAST_MUL_EN to complete all multiplies through one
// combinational DATA_WIDTH x DATA_WIDTH multiplier, so they finish in a single cycle.
// Divides are iterative in both builds.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        request, sampled only when busy_o is low
//   flush_i        abort any in-flight op and return to idle at the next edge
//   mul_div_op_i   RISC-V funct3 encoding of the operation
//   src_a_i        multiplicand / dividend
//   src_b_i        multiplier / divisor
//   busy_o         high while iterating
//   done_o         one-cycle pulse; result_o is valid
//   result_o       held from done_o until the next completed operation
//   div_by_zero_o  qualifies done_o; divide op had a zero divisor
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 3,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [OP_WIDTH-1:0]   mul_div_op_i,
  input  logic [DATA_WIDTH-1:0] src_a_i,
  input  logic [DATA_WIDTH-1:0] src_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  div_by_zero_o
);

  localparam int unsigned W = DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic                  neg_q, neg_d;
  logic [W-1:0]          opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [2*W-1:0]        acc_q, acc_d;      // product, or {remainder, quotient}
  logic [W-1:0]          result_q, result_d;
  logic                  dbz_q, dbz_d;

  // Sign-corrects the finished accumulator and picks the architectural result.
  function automatic logic [W-1:0] select_result(input logic is_div, input logic is_rem,
                                                 input logic is_lo, input logic neg,
                                                 input logic [2*W-1:0] acc);
    logic [2*W-1:0] prod;
    logic [W-1:0]   sel;
    if (!is_div) begin
      // Negate the full product so the high half carries the borrow correctly.
      prod = neg ? -acc : acc;
      sel  = is_lo ? prod[W-1:0] : prod[2*W-1:W];
    end else begin
      sel = is_rem ? acc[2*W-1:W] : acc[W-1:0];
      if (neg) begin
        sel = -sel;
      end
    end
    return sel;
  endfunction

  // Decode of the incoming request.
  logic         in_div, in_rem, in_a_signed, in_b_signed;
  logic         a_neg, b_neg, in_neg, in_div_zero, in_ovf;
  logic [W-1:0] a_mag, b_mag;

  assign in_div      = mul_div_op_i[2];
  assign in_rem      = mul_div_op_i[2] & mul_div_op_i[1];
  assign in_a_signed = in_div ? ~mul_div_op_i[0] : (mul_div_op_i[1] ^ mul_div_op_i[0]);
  assign in_b_signed = in_div ? ~mul_div_op_i[0] : (mul_div_op_i[1:0] == 2'b01);
  assign a_neg       = in_a_signed & src_a_i[W-1];
  assign b_neg       = in_b_signed & src_b_i[W-1];
  assign a_mag       = a_neg ? -src_a_i : src_a_i;
  assign b_mag       = b_neg ? -src_b_i : src_b_i;
  // Remainder takes the dividend's sign; quotient and products take the XOR.
  assign in_neg      = (in_div && in_rem) ? a_neg : (a_neg ^ b_neg);
  assign in_div_zero = in_div & (src_b_i == '0);
  assign in_ovf      = in_div & ~mul_div_op_i[0] & (src_a_i == {1'b1, {(W-1){1'b0}}}) &
                       (src_b_i == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic           in_mul_lo;
  logic [2*W-1:0] fast_prod;
  assign in_mul_lo = (mul_div_op_i[2:0] == 3'b000);
  assign fast_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`endif

  // One iteration of the core.
  logic           q_div, q_rem, q_lo;
  logic [W:0]     mul_sum;
  logic [W:0]     div_diff;
  logic [2*W-1:0] step_acc;

  assign q_div = op_q[2];
  assign q_rem = op_q[2] & op_q[1];
  assign q_lo  = (op_q[2:0] == 3'b000);

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    // Partial remainder shifted left; the bit shifted out joins the trial subtraction.
    div_diff = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    if (!q_div) begin
      step_acc = {mul_sum, acc_q[W-1:1]};
    end else if (div_diff[W]) begin
      step_acc = {acc_q[2*W-2:0], 1'b0};
    end else begin
      step_acc = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      StCalc: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d  = StDone;
          result_d = select_result(q_div, q_rem, q_lo, neg_q, step_acc);
          dbz_d    = 1'b0;
        end
      end
      default: begin
        if (state_q == StDone) begin
          state_d = StIdle;
        end
        if (start_i) begin
          op_d   = mul_div_op_i;
          neg_d  = in_neg;
          opnd_d = in_div ? b_mag : a_mag;
          acc_d  = {{W{1'b0}}, (in_div ? a_mag : b_mag)};
          if (in_div_zero) begin
            state_d  = StDone;
            result_d = in_rem ? src_a_i : '1;
            dbz_d    = 1'b1;
          end else if (in_ovf) begin
            state_d  = StDone;
            result_d = in_rem ? '0 : src_a_i;
            dbz_d    = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!in_div) begin
            state_d  = StDone;
            result_d = select_result(1'b0, 1'b0, in_mul_lo, in_neg, fast_prod);
            dbz_d    = 1'b0;
`endif
          end else begin
            state_d = StCalc;
            cnt_d   = CNT_WIDTH'(W);
          end
        end
      end
    endcase

    // Flush wins over everything and never touches the visible result.
    if (flush_i) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
      dbz_d    = dbz_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy_o        = (state_q == StCalc);
  assign done_o        = (state_q == StDone);
  assign result_o      = result_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  mul_div_op_i = '0;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        busy_o, done_o, div_by_zero_o;
  logic [31:0] result_o;

  muldiv_unit #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .flush_i(flush_i),
    .mul_div_op_i(mul_div_op_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the architectural definition of each op.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output int lat);
    logic [63:0] p;
    logic        ovf;
    z   = op[2] && (b == 32'd0);
    ovf = (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    p   = '0;
    r   = '0;
    case (op)
      3'd0: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); r = p[31:0]; end
      3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); r = p[63:32]; end
      3'd2: begin p = 64'(longint'($signed(a)) * longint'({32'd0, b})); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (z) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else r = 32'($signed(a) / $signed(b));
      end
      3'd5: r = z ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (z) r = a;
        else if (ovf) r = 32'd0;
        else r = 32'($signed(a) % $signed(b));
      end
      default: r = z ? a : a % b;
    endcase
    lat = (z || ovf || (Fast && !op[2])) ? 1 : 33;
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    exp_t        e;
    logic [31:0] r;
    logic        z;
    model(op, a, b, r, z, lat);
    mul_div_op_i = op;
    src_a_i      = a;
    src_b_i      = b;
    start_i      = 1'b1;
    e.res = r;
    e.dbz = z;
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk_i);
    start_i      = 1'b0;
    mul_div_op_i = 3'($urandom_range(0, 7));
    src_a_i      = $urandom;
    src_b_i      = $urandom;
  endtask

  // Monitor: pops the scoreboard on every done pulse, and flags overdue entries.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got result=%h expected no done", result_o);
        end else begin
          e = sb.pop_front();
          check("result", result_o, e.res);
          check("div_by_zero", {31'd0, div_by_zero_o}, {31'd0, e.dbz});
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_done got none expected done at cycle %0d", sb[0].cyc);
        e = sb.pop_front();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs [11] = '{
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
    '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0},
    '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0},
    '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0},
    '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0},
    '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0},
    '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1},
    '{3'd6, 32'd5,         32'd0,         32'd5,         1'b1},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0}
  };

  initial begin
    int lat;
    int busy_cnt;
    int gap;

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // MUL 7 x -3 with busy profile.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, lat);
    busy_cnt = int'(busy_o);
    for (int i = 2; i <= lat; i++) begin
      @(negedge clk_i);
      busy_cnt += int'(busy_o);
    end
    check("mul_result", result_o, 32'hFFFF_FFEB);
    check("mul_busy_cycles", 32'(busy_cnt), Fast ? 32'd0 : 32'd32);

    // Directed vectors, each started in the previous op's done cycle.
    foreach (vecs[k]) begin
      issue(vecs[k].op, vecs[k].a, vecs[k].b, lat);
      repeat (lat - 1) @(negedge clk_i);
      check("vec_result", result_o, vecs[k].r);
      check("vec_dbz", {31'd0, div_by_zero_o}, {31'd0, vecs[k].z});
    end
    @(negedge clk_i);

    // Start while busy is ignored.
    issue(3'd5, 32'd100, 32'd7, lat);
    repeat (9) @(negedge clk_i);
    mul_div_op_i = 3'd0;
    src_a_i      = 32'd3;
    src_b_i      = 32'd3;
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (lat - 11) @(negedge clk_i);
    check("ignored_start_result", result_o, 32'd14);

    // Back-to-back start in the done cycle.
    issue(3'd7, 32'd100, 32'd7, lat);
    repeat (lat - 1) @(negedge clk_i);
    check("b2b_result", result_o, 32'd2);
    @(negedge clk_i);

    // Flush mid-calculation.
    issue(3'd5, 32'd1000, 32'd3, lat);
    repeat (14) @(negedge clk_i);
    flush_i = 1'b1;
    void'(sb.pop_back());
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_done", {31'd0, done_o}, 32'd0);
    check("flush_result", result_o, 32'd2);
    // Flush overrides a simultaneous start.
    mul_div_op_i = 3'd4;
    src_a_i      = 32'd5;
    src_b_i      = 32'd0;
    start_i      = 1'b1;
    flush_i      = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush_start_done", {31'd0, done_o}, 32'd0);
    repeat (40) @(negedge clk_i);
    check("flush_result_kept", result_o, 32'd2);

    // Asynchronous reset mid-calculation.
    issue(3'd5, 32'd1000, 32'd3, lat);
    repeat (19) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    sb.delete();
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_done", {31'd0, done_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    check("arst_dbz", {31'd0, div_by_zero_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, lat);
    repeat (lat - 1) @(negedge clk_i);
    check("restart_result", result_o, 32'hFFFF_FFEB);

    // Randomized operations with random idle gaps.
    for (int n = 0; n < 120; n++) begin
      issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), lat);
      repeat (lat - 1) @(negedge clk_i);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk_i);
    end

    repeat (40) @(negedge clk_i);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, the parametrised multi-cycle successor to the single-cycle ALU in the execute stage. It accepts one operation per Start handshake and computes all eight M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Its shift-add/restoring core resolves one bit per cycle. The hazard unit stalls the pipeline on Busy and forwards Result on the Done pulse.

## Interface
- DATA_WIDTH, 32, operand/result width (even, >= 8)
- OP_WIDTH, 3, width of MulDivOp (RISC-V funct3 encoding)
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width

- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- Start  input  1  request; sampled only when Busy=0
- Flush  input  1  abort any in-flight op; return to IDLE next edge
- MulDivOp  input  OP_WIDTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  DATA_WIDTH  multiplicand / dividend
- SrcB  input  DATA_WIDTH  multiplier / divisor
- Busy  output  1  high while in CALC
- Done  output  1  one-cycle pulse; Result valid
- Result  output  DATA_WIDTH  held from Done until the next accepted Start
- DivByZero  output  1  qualifies Done; high when a DIV/DIVU/REM/REMU had SrcB=0

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- IDLE or DONE, Start=1, Flush=0: latch op and operands.
  - Normal case: go to CALC with counter=DATA_WIDTH.
  - Special case: go straight to DONE.
- CALC: one bit per cycle, counter decrements. When counter reaches 1, the next state is DONE.
- DONE: Done=1 for exactly one cycle.
  - Start in the same cycle is accepted (back-to-back).
  - Otherwise go to IDLE.
- Flush=1 forces IDLE at the next edge from any state.
  - Flush overrides a simultaneous Start.
  - Flush suppresses Done and leaves Result unchanged.
- Operand and result sign handling:
  - Signed operands (MULH: both; MULHSU: SrcA only; DIV/REM: both) are converted to magnitudes at latch time.
  - The core is unsigned, with a 2*DATA_WIDTH product/remainder register.
  - The result is conditionally two's-complement negated on entry to DONE.
- Result selection:
  - MUL returns product[DATA_WIDTH-1:0]; MULH, MULHSU and MULHU return product[2*DATA_WIDTH-1:DATA_WIDTH].
  - Quotient sign = signA XOR signB; remainder sign = signA.
- Special cases (no CALC):
  - Divide by zero: quotient = all ones; remainder = SrcA; DivByZero=1.
  - Signed overflow (SrcA = most-negative, SrcB = -1, DIV/REM): quotient = SrcA; remainder = 0.
- Operands are sampled once. Changes on SrcA, SrcB or MulDivOp after acceptance have no effect.

## Timing
- Reset (rst_n=0, asynchronous, any state, including mid-CALC):
  - State=IDLE, Busy=0, Done=0, DivByZero=0, Result=0, counter=0.
  - Internal registers are cleared.
- Start accepted at edge 0:
  - Normal ops: Busy=1 for cycles 1..DATA_WIDTH; Done=1 in cycle DATA_WIDTH+1 (latency 33 at default width).
  - Special cases: Done=1 in cycle 1; Busy stays 0.
- Start while Busy=1 is ignored. The request is not queued.
- Result and DivByZero change only on the edge entering DONE.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single combinational DATA_WIDTH x DATA_WIDTH multiplier.
  - They go IDLE/DONE -> DONE directly, so Done arrives in cycle 1 with Busy=0.
  - Divide ops are unchanged.
- Undefined: all multiplies are iterative, with DATA_WIDTH+1 latency.

## Test plan
- MUL 7 x 0xFFFFFFFD (-3): Result=0xFFFFFFEB, Done in cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN), Busy high for cycles 1-32.
- MULH 0x80000000 x 0x80000000: Result=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF: Result=0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2: Result=0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2: Result=0xFFFFFFFD. REM: Result=0xFFFFFFFF. DIVU 100/7: 14. REMU: 2.
- DIV 5 / 0: Result=0xFFFFFFFF, DivByZero=1, Done in cycle 1. REM 5/0: Result=5. DIV 0x80000000 / 0xFFFFFFFF: Result=0x80000000. REM: Result=0.
- Start a second op in cycle 10 while Busy: it is ignored and the first result is intact. Start in the Done cycle: the new op completes 33 cycles later.
- Flush in cycle 15: no Done, Busy=0 next cycle, prior Result kept. rst_n low in cycle 20: all outputs 0 immediately (asynchronous), then a clean restart.
